// File: rtl/game_if.sv
`default_nettype none
// ============================================================
// game_if : key/miss inputs and status outputs of game_fsm
// Revision: 1.0
// ============================================================
interface game_if;
  logic       serve_a_key;
  logic       serve_b_key;
  logic       ESC_state;
  logic       miss_a;
  logic       miss_b;
  logic [3:0] state;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic       serve_dir;
  logic       ball_rst;
  logic       frame_tick;
  logic       winner;

  modport master (
    output serve_a_key, serve_b_key, ESC_state, miss_a, miss_b,
    input  state, score_a, score_b, serve_dir, ball_rst, frame_tick, winner
  );

  modport slave (
    input  serve_a_key, serve_b_key, ESC_state, miss_a, miss_b,
    output state, score_a, score_b, serve_dir, ball_rst, frame_tick, winner
  );
endinterface
`default_nettype wire

// File: rtl/game_fsm.sv
`default_nettype none
// ============================================================
// game_fsm : tennis match sequencer, scoring and frame tick
// Revision: 1.0
// ============================================================
module game_fsm #(
  parameter int TICK_DIV    = 1000000,
  parameter int POINT_TICKS = 50,
  parameter int WIN_SCORE   = 7
) (
  input wire    clk,
  input wire    start,
  game_if.slave bus
);

  localparam int         c_cnt_w = $clog2(TICK_DIV + 1);
  localparam int         c_pt_w  = $clog2(POINT_TICKS + 1);
  localparam logic [3:0] c_win   = 4'(WIN_SCORE);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SERVE_A   = 4'd1,
    SERVE_B   = 4'd2,
    PLAY      = 4'd3,
    POINT     = 4'd4,
    PAUSE     = 4'd5,
    GAME_OVER = 4'd6
  } state_t;

  state_t              r_state;
  state_t              r_saved;
  logic [2:0]          r_key;
  logic [2:0]          r_key_prev;
  logic [1:0]          r_miss;
  logic [3:0]          r_score_a;
  logic [3:0]          r_score_b;
  logic                r_serve_dir;
  logic                r_ball_rst;
  logic                r_frame_tick;
  logic                r_winner;
  logic                r_next_srv;
  logic [c_cnt_w-1:0]  r_tick_cnt;
  logic [c_pt_w-1:0]   r_pt_cnt;
  logic [2:0]          w_key_ev;
  logic                w_win_hit;

  // key event bits: [0] serve A, [1] serve B, [2] ESC
  assign w_key_ev  = r_key & ~r_key_prev;
  assign w_win_hit = (r_score_a == c_win) || (r_score_b == c_win);

  always_ff @(posedge clk) begin
    if (!start) begin
      r_state      <= IDLE;
      r_saved      <= IDLE;
      r_key        <= '0;
      r_key_prev   <= '0;
      r_miss       <= '0;
      r_score_a    <= '0;
      r_score_b    <= '0;
      r_serve_dir  <= 1'b0;
      r_ball_rst   <= 1'b1;
      r_frame_tick <= 1'b0;
      r_winner     <= 1'b0;
      r_next_srv   <= 1'b0;
      r_tick_cnt   <= '0;
      r_pt_cnt     <= '0;
    end else begin
      r_key      <= {bus.ESC_state, bus.serve_b_key, bus.serve_a_key};
      r_key_prev <= r_key;
      r_miss     <= {bus.miss_b, bus.miss_a};

      if (r_state == PAUSE) begin
        r_frame_tick <= 1'b0;
      end else if (r_tick_cnt == c_cnt_w'(TICK_DIV - 1)) begin
        r_tick_cnt   <= '0;
        r_frame_tick <= 1'b1;
      end else begin
        r_tick_cnt   <= r_tick_cnt + c_cnt_w'(1);
        r_frame_tick <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_key_ev[0] || w_key_ev[1]) begin
            r_score_a   <= '0;
            r_score_b   <= '0;
            r_state     <= SERVE_A;
            r_serve_dir <= 1'b0;
            r_ball_rst  <= 1'b1;
          end
        end
        SERVE_A, SERVE_B: begin
          if (w_key_ev[2]) begin
            r_saved <= r_state;
            r_state <= PAUSE;
          end else if ((r_state == SERVE_A && w_key_ev[0]) ||
                       (r_state == SERVE_B && w_key_ev[1])) begin
            r_state    <= PLAY;
            r_ball_rst <= 1'b0;
          end
        end
        PLAY: begin
          if (w_key_ev[2]) begin
            r_saved <= r_state;
            r_state <= PAUSE;
          end else if (|r_miss) begin
            r_state    <= POINT;
            r_ball_rst <= 1'b1;
            r_pt_cnt   <= '0;
            case (r_miss)
              2'b01: begin
                if (r_score_b < c_win) r_score_b <= r_score_b + 4'd1;
                r_next_srv <= 1'b0;
              end
              2'b10: begin
                if (r_score_a < c_win) r_score_a <= r_score_a + 4'd1;
                r_next_srv <= 1'b1;
              end
              default: r_next_srv <= r_serve_dir;
            endcase
          end
        end
        POINT: begin
          if (w_win_hit) begin
            r_state  <= GAME_OVER;
            r_winner <= (r_score_b == c_win);
          end else if (r_frame_tick) begin
            if (r_pt_cnt == c_pt_w'(POINT_TICKS - 1)) begin
              r_state     <= r_next_srv ? SERVE_B : SERVE_A;
              r_serve_dir <= r_next_srv;
            end else begin
              r_pt_cnt <= r_pt_cnt + c_pt_w'(1);
            end
          end
        end
        PAUSE: begin
          if (w_key_ev[2]) r_state <= r_saved;
        end
        GAME_OVER: begin
          if (w_key_ev[0] || w_key_ev[1]) r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_ball_rst <= 1'b1;
        end
      endcase
    end
  end

  assign bus.state      = r_state;
  assign bus.score_a    = r_score_a;
  assign bus.score_b    = r_score_b;
  assign bus.serve_dir  = r_serve_dir;
  assign bus.ball_rst   = r_ball_rst;
  assign bus.frame_tick = r_frame_tick;
  assign bus.winner     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_game_fsm.sv
`default_nettype none
// ============================================================
// tb_game_fsm : directed + random stimulus against a match model
// Revision: 1.0
// ============================================================
module tb_game_fsm;

  localparam int TD  = 4;
  localparam int PT  = 2;
  localparam int WIN = 3;

  logic clk;
  logic start;
  int   total;
  int   bad;

  game_if bus ();

  game_fsm #(
    .TICK_DIV    (TD),
    .POINT_TICKS (PT),
    .WIN_SCORE   (WIN)
  ) dut (
    .clk   (clk),
    .start (start),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: game status after each clock edge
  int       m_st, m_sa, m_sb, m_dir, m_brst, m_ft, m_win, m_saved, m_next, m_pt, m_act;
  bit [2:0] m_kr, m_kp;
  bit [1:0] m_mr;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_sa = 0; m_sb = 0; m_dir = 0; m_brst = 1; m_ft = 0; m_win = 0;
    m_saved = 0; m_next = 0; m_pt = 0; m_act = 0;
    m_kr = '0; m_kp = '0; m_mr = '0;
  endtask

  task automatic enter_serve(input int who);
    m_st   = 1 + who;
    m_dir  = who;
    m_brst = 1;
  endtask

  task automatic model_edge(input bit s, input bit [2:0] keys, input bit [1:0] miss);
    bit [2:0] ev;
    bit       was_paused;
    if (!s) begin
      model_reset();
      return;
    end
    ev         = m_kr & ~m_kp;
    was_paused = (m_st == 5);
    case (m_st)
      0: if (ev[0] || ev[1]) begin m_sa = 0; m_sb = 0; enter_serve(0); end
      1, 2: begin
        if (ev[2]) begin m_saved = m_st; m_st = 5; end
        else if ((m_st == 1) ? ev[0] : ev[1]) begin m_st = 3; m_brst = 0; end
      end
      3: begin
        if (ev[2]) begin m_saved = m_st; m_st = 5; end
        else if (m_mr != 0) begin
          if (m_mr == 2'b01) begin if (m_sb < WIN) m_sb++; m_next = 0; end
          else if (m_mr == 2'b10) begin if (m_sa < WIN) m_sa++; m_next = 1; end
          else m_next = m_dir;
          m_st = 4; m_brst = 1; m_pt = 0;
        end
      end
      4: begin
        if (m_sa == WIN || m_sb == WIN) begin m_st = 6; m_win = (m_sb == WIN) ? 1 : 0; end
        else if (m_ft != 0) begin
          m_pt++;
          if (m_pt == PT) enter_serve(m_next);
        end
      end
      5: if (ev[2]) m_st = m_saved;
      6: if (ev[0] || ev[1]) m_st = 0;
      default: m_st = 0;
    endcase
    if (was_paused) m_ft = 0;
    else begin
      m_act++;
      m_ft = (m_act % TD == 0) ? 1 : 0;
    end
    m_kp = m_kr;
    m_kr = keys;
    m_mr = miss;
  endtask

  task automatic compare_all();
    check_val("state",      int'(bus.state),      m_st);
    check_val("score_a",    int'(bus.score_a),    m_sa);
    check_val("score_b",    int'(bus.score_b),    m_sb);
    check_val("serve_dir",  int'(bus.serve_dir),  m_dir);
    check_val("ball_rst",   int'(bus.ball_rst),   m_brst);
    check_val("frame_tick", int'(bus.frame_tick), m_ft);
    check_val("winner",     int'(bus.winner),     m_win);
  endtask

  task automatic step(input bit s, input bit a, input bit b, input bit e, input bit ma, input bit mb);
    @(negedge clk);
    start           = s;
    bus.serve_a_key = a;
    bus.serve_b_key = b;
    bus.ESC_state   = e;
    bus.miss_a      = ma;
    bus.miss_b      = mb;
    @(posedge clk);
    model_edge(s, {e, b, a}, {mb, ma});
    #1;
    compare_all();
  endtask

  // hold one input pattern for n cycles, then optionally check a known state code
  task automatic seg(input bit s, input bit a, input bit b, input bit e,
                     input bit ma, input bit mb, input int n, input int exp_st);
    for (int i = 0; i < n; i++) step(s, a, b, e, ma, mb);
    if (exp_st >= 0) check_val("seq_state", int'(bus.state), exp_st);
  endtask

  initial begin
    bit a, b, e, ma, mb, s;
    total = 0;
    bad   = 0;
    model_reset();
    start = 1'b0;
    bus.serve_a_key = 1'b0; bus.serve_b_key = 1'b0; bus.ESC_state = 1'b0;
    bus.miss_a = 1'b0; bus.miss_b = 1'b0;

    seg(0, 1, 1, 0, 0, 0,  3, 0);
    seg(1, 0, 0, 0, 0, 0,  4, 0);
    seg(1, 1, 0, 0, 0, 0,  2, 1);
    seg(1, 0, 0, 0, 0, 0,  3, 1);
    seg(1, 1, 0, 0, 0, 0,  2, 3);
    seg(1, 0, 0, 0, 0, 0,  2, 3);
    seg(1, 0, 0, 0, 0, 1,  1, -1);
    seg(1, 0, 0, 0, 0, 0,  1, 4);
    seg(1, 0, 0, 0, 0, 0, 12, 2);
    seg(1, 0, 1, 0, 0, 0, 20, 3);
    seg(1, 0, 0, 0, 0, 0,  2, 3);
    seg(1, 0, 0, 0, 1, 1,  1, -1);
    seg(1, 0, 0, 0, 0, 0, 12, 2);
    seg(1, 0, 1, 0, 0, 0,  2, 3);
    seg(1, 0, 0, 0, 0, 0,  1, 3);
    seg(1, 0, 0, 1, 0, 0,  2, 5);
    seg(1, 0, 0, 0, 0, 0,  3, 5);
    seg(1, 0, 0, 0, 1, 0,  1, -1);
    seg(1, 0, 0, 0, 0, 0, 12, 5);
    seg(1, 0, 0, 1, 0, 0,  2, 3);
    seg(1, 0, 0, 0, 0, 0,  2, 3);
    seg(1, 0, 0, 1, 0, 1,  1, -1);
    seg(1, 0, 0, 0, 0, 0,  3, 5);
    seg(1, 0, 0, 1, 0, 0,  2, 3);
    seg(1, 0, 0, 0, 0, 0,  2, 3);
    for (int k = 0; k < 2; k++) begin
      seg(1, 0, 0, 0, 1, 0,  1, -1);
      seg(1, 0, 0, 0, 0, 0, 12, 1);
      seg(1, 1, 0, 0, 0, 0,  2, 3);
      seg(1, 0, 0, 0, 0, 0,  2, 3);
    end
    seg(1, 0, 0, 0, 1, 0,  1, -1);
    seg(1, 0, 0, 0, 0, 0,  1, 4);
    seg(1, 0, 0, 0, 0, 0,  1, 6);
    check_val("winner_b", int'(bus.winner), 1);
    check_val("final_score_b", int'(bus.score_b), WIN);
    seg(1, 0, 0, 0, 0, 0,  4, 6);
    seg(1, 1, 0, 0, 0, 0,  2, 0);
    check_val("idle_score_b", int'(bus.score_b), WIN);
    seg(1, 0, 0, 0, 0, 0,  2, 0);
    seg(1, 0, 1, 0, 0, 0,  2, 1);
    check_val("new_match_score_b", int'(bus.score_b), 0);
    seg(1, 0, 0, 0, 0, 0,  2, 1);
    seg(1, 1, 0, 0, 0, 0,  2, 3);
    seg(1, 0, 0, 0, 0, 0,  2, 3);
    seg(0, 0, 0, 0, 0, 0,  1, 0);
    seg(1, 0, 0, 0, 0, 0,  2, 0);

    a = 0; b = 0; e = 0; ma = 0; mb = 0; s = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0)  a = ~a;
      if ($urandom_range(7) == 0)  b = ~b;
      if ($urandom_range(24) == 0) e = ~e;
      ma = !ma && ($urandom_range(15) == 0);
      mb = !mb && ($urandom_range(15) == 0);
      s  = ($urandom_range(599) != 0);
      step(s, a, b, e, ma, mb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
